// File: rtl/n64_pkg.sv
// n64_pkg: FSM encoding, frame constants and checksum shared by the N64 UART transmitter.
package n64_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam int FRAME_BYTES = 6;
  localparam int BITS_PER_BYTE = 10;
  localparam logic [7:0] DEF_SYNC = 8'hA5;
  function automatic logic [7:0] chk(input logic [31:0] w);
    return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
  endfunction
endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serialiser with per-bit baud counter; a byte offered in the last
// stop cycle is taken immediately so consecutive bytes run with no idle gap.
module uart_byte_tx import n64_pkg::*; #(
  parameter int DIV = 286
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);
  localparam int CW = $clog2(DIV);
  tx_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(DIV - 1);
  assign byte_ready = state == IDLE || (state == STOP && last);
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = byte_valid ? START : IDLE;
    else if (last)
      state_n = state == START ? DATA :
                state == STOP  ? (byte_valid ? START : IDLE) :
                bit_idx == 3'(BITS_PER_BYTE - 3) ? STOP : DATA;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      cnt <= '0;
      bit_idx <= '0;
      sh <= '0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      bit_idx <= state != DATA ? '0 : last ? bit_idx + 1'b1 : bit_idx;
      if (byte_valid && byte_ready) sh <= byte_in;
    end
  // Decoded straight from state so an async reset idles the line at once.
  assign tx = state == START ? 1'b0 : state == DATA ? sh[bit_idx] : 1'b1;
endmodule

// File: rtl/n64_uart_tx.sv
// n64_uart_tx: frames each controller word as SYNC,b3,b2,b1,b0,XOR and sends it 8N1.
// Define N64_UART_CHANGE_ONLY_EN to drop words equal to the last sent or the pending word.
module n64_uart_tx import n64_pkg::*; #(
  parameter int CLK_FREQ = 33_000_000,
  parameter int BAUD = 115_200,
  parameter logic [7:0] SYNC_BYTE = DEF_SYNC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  output logic        uart_tx,
  output logic        busy,
  output logic [7:0]  drop_cnt
);
  localparam int DIV = CLK_FREQ / BAUD;
  logic [1:0] rst_q;
  logic rst_n_i, accept, start_frame, byte_valid, byte_ready, take, done, pend_v;
  logic [31:0] word, pend;
  logic [2:0] idx;
  logic [7:0] byte_in;
  // Assert asynchronously, release two edges later.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  assign rst_n_i = rst_q[1];
`ifdef N64_UART_CHANGE_ONLY_EN
  logic [31:0] last_sent;
  logic first_flag;
  assign accept = data_valid && !((!first_flag && data_in == last_sent) || (pend_v && data_in == pend));
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      last_sent <= '0;
      first_flag <= 1'b1;
    end else if (start_frame) begin
      last_sent <= pend_v ? pend : data_in;
      first_flag <= 1'b0;
    end
`else
  assign accept = data_valid;
`endif
  assign start_frame = !busy && (pend_v || accept);
  assign byte_valid = start_frame || (busy && idx != 3'(FRAME_BYTES));
  assign take = byte_valid && byte_ready;
  assign done = busy && idx == 3'(FRAME_BYTES) && byte_ready;
  assign byte_in = idx == 3'd0 ? SYNC_BYTE :
                   idx == 3'd1 ? word[31:24] :
                   idx == 3'd2 ? word[23:16] :
                   idx == 3'd3 ? word[15:8] :
                   idx == 3'd4 ? word[7:0] : chk(word);
  // A word arriving in the completion cycle counts as busy and lands in pending.
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      busy <= 1'b0;
      idx <= '0;
      word <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (start_frame) begin
        busy <= 1'b1;
        word <= pend_v ? pend : data_in;
        idx <= 3'd1;
      end else if (done) begin
        busy <= 1'b0;
        idx <= '0;
      end else if (take) idx <= idx + 1'b1;
      pend_v <= busy ? (pend_v || accept) : (pend_v && accept);
      if (accept && (busy || pend_v)) pend <= data_in;
      if (accept && busy && pend_v && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  uart_byte_tx #(.DIV(DIV)) u_byte (
    .clk(clk),
    .reset_n(rst_n_i),
    .byte_in(byte_in),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx(uart_tx)
  );
endmodule

// File: tb/tb_n64_uart_tx.sv
// tb_n64_uart_tx: table vectors, hand-written corner sequences and a random run
// checked by a line decoder against a frame-timing reference model.
module tb_n64_uart_tx;
  localparam int DIV = 10;
  localparam int FRAME = 60 * DIV;
  localparam logic [7:0] SYNC = 8'hA5;
  typedef struct {logic [31:0] w; logic [7:0] c;} vec_t;
  typedef struct {int t; logic [47:0] b; logic ok;} fr_t;
  typedef struct {int t; logic [31:0] w;} ex_t;
  logic clk = 1'b0;
  logic reset_n, data_valid, uart_tx, busy, mon_en;
  logic [31:0] data_in;
  logic [7:0] drop_cnt;
  int total = 0, bad = 0, cyc = 0;
  vec_t vecs[7];
  fr_t dec[$];
  ex_t expq[$];
  int m_end, m_drop;
  logic m_pv, m_first;
  logic [31:0] m_pw, m_last;
  n64_uart_tx #(.CLK_FREQ(1000), .BAUD(100)) dut (
    .clk(clk), .reset_n(reset_n), .data_in(data_in), .data_valid(data_valid),
    .uart_tx(uart_tx), .busy(busy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [47:0] exp48(input logic [31:0] w);
    return {SYNC, w, w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0]};
  endfunction
  function automatic logic [59:0] fbits(input logic [47:0] b);
    logic [59:0] f;
    for (int j = 0; j < 6; j++) begin
      f[j*10] = 1'b0;
      for (int i = 0; i < 8; i++) f[j*10+1+i] = b[40-8*j+i];
      f[j*10+9] = 1'b1;
    end
    return f;
  endfunction
  // Line decoder: samples mid-bit across a whole frame after the first low sample.
  initial begin
    logic [59:0] bits;
    fr_t f;
    forever begin
      @(negedge clk);
      if (mon_en && reset_n && uart_tx === 1'b0) begin
        f.t = cyc;
        for (int o = 0; o < FRAME; o++) begin
          if (o % DIV == DIV / 2) bits[o/DIV] = uart_tx;
          if (o < FRAME - 1) @(negedge clk);
        end
        f.ok = 1'b1;
        for (int j = 0; j < 6; j++) begin
          for (int i = 0; i < 8; i++) f.b[40-8*j+i] = bits[j*10+1+i];
          if (bits[j*10] !== 1'b0 || bits[j*10+9] !== 1'b1) f.ok = 1'b0;
        end
        dec.push_back(f);
      end
    end
  end
  task automatic m_start(input int t, input logic [31:0] w);
    expq.push_back('{t, w});
    m_end = t + FRAME;
    m_last = w;
    m_first = 1'b0;
  endtask
  // Reference: a frame started at edge t keeps the block busy through edge t+FRAME.
  task automatic model_step(input int t, input logic dv, input logic [31:0] d);
    logic a;
    a = dv;
`ifdef N64_UART_CHANGE_ONLY_EN
    if (dv && ((!m_first && d == m_last) || (m_pv && d == m_pw))) a = 1'b0;
`endif
    if (t <= m_end) begin
      if (a) begin
        if (m_pv && m_drop < 255) m_drop++;
        m_pv = 1'b1;
        m_pw = d;
      end
    end else if (m_pv) begin
      m_start(t, m_pw);
      m_pv = a;
      if (a) m_pw = d;
    end else if (a) m_start(t, d);
  endtask
  task automatic cmp_frames(input string name);
    logic [47:0] e;
    check({name, " frames"}, dec.size(), expq.size());
    for (int i = 0; i < dec.size() && i < expq.size(); i++) begin
      e = exp48(expq[i].w);
      check($sformatf("%s f%0d bytes", name, i), dec[i].b, e);
      check($sformatf("%s f%0d framing", name, i), dec[i].ok, 1);
      if (expq[i].t >= 0) check($sformatf("%s f%0d start", name, i), dec[i].t, expq[i].t);
    end
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask
  task automatic send_and_check(input string name, input logic [31:0] w, input logic [7:0] c);
    logic [59:0] fb;
    int le, be;
    fb = fbits({SYNC, w, c});
    le = 0;
    be = 0;
    @(negedge clk);
    data_in = w;
    data_valid = 1'b1;
    @(negedge clk);
    data_valid = 1'b0;
    check({name, " latency"}, uart_tx, 0);
    for (int k = 0; k < FRAME; k++) begin
      if (k > 0) @(negedge clk);
      if (uart_tx !== fb[k/DIV]) le++;
      if (busy !== 1'b1) be++;
    end
    check({name, " line errs"}, le, 0);
    check({name, " busy errs"}, be, 0);
    @(negedge clk);
    check({name, " idle after"}, {busy, uart_tx}, 2'b01);
  endtask
  initial begin
    logic [59:0] fb1, fb3;
    logic el, eb, prev;
    int le, be, edges, nxt;
    logic [31:0] w, pw;
    logic dv;
    logic [31:0] cw[4];
    vecs = '{'{32'h1234_5678, 8'h08}, '{32'h0000_0001, 8'h01}, '{32'hFFFF_FFFF, 8'h00},
             '{32'h8000_0000, 8'h80}, '{32'hA5A5_A5A5, 8'h00}, '{32'h0F0F_00FF, 8'hFF},
             '{32'h00FF_0F01, 8'hF1}};
    reset_n = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    check("in reset", {uart_tx, busy, drop_cnt}, {1'b1, 1'b0, 8'h00});
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("after reset", {uart_tx, busy, drop_cnt}, {1'b1, 1'b0, 8'h00});
    edges = 0;
    prev = uart_tx;
    repeat (1000) begin
      @(negedge clk);
      if (uart_tx !== prev) edges++;
      prev = uart_tx;
    end
    check("idle edges", edges, 0);
    for (int i = 0; i < 7; i++) send_and_check($sformatf("vec%0d", i), vecs[i].w, vecs[i].c);
    // Second word pends, third overwrites it: frames 1 and 3 with one idle cycle between.
    fb1 = fbits(exp48(32'h1));
    fb3 = fbits(exp48(32'h3));
    le = 0;
    be = 0;
    @(negedge clk);
    data_in = 32'h1;
    data_valid = 1'b1;
    for (int k = 0; k <= 2 * FRAME + 1; k++) begin
      @(negedge clk);
      el = k < FRAME ? fb1[k/DIV] : k == FRAME ? 1'b1 : k < 2 * FRAME + 1 ? fb3[(k-FRAME-1)/DIV] : 1'b1;
      eb = k < FRAME || (k > FRAME && k < 2 * FRAME + 1);
      if (uart_tx !== el) le++;
      if (busy !== eb) be++;
      data_valid = k == 100 || k == 200;
      data_in = k == 100 ? 32'h2 : 32'h3;
    end
    check("b2b line errs", le, 0);
    check("b2b busy errs", be, 0);
    check("b2b drops", drop_cnt, 1);
    @(negedge clk);
    data_in = 32'h1234_5678;
    data_valid = 1'b1;
    for (int k = 0; k <= 245; k++) begin
      @(negedge clk);
      data_valid = 1'b0;
    end
    check("mid pre tx", uart_tx, 0);
    reset_n = 1'b0;
    #1;
    check("mid async tx", uart_tx, 1);
    check("mid async busy", busy, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check("mid released", {uart_tx, busy}, 2'b10);
    send_and_check("post rst", 32'hCAFE_F00D, 8'hC9);
    do_reset();
    for (int i = 0; i < 302; i++) begin
      @(negedge clk);
      if (i == 200) check("sat 198", drop_cnt, 198);
      if (i == 256) check("sat 254", drop_cnt, 254);
      if (i == 257) check("sat 255", drop_cnt, 255);
      data_in = 32'd100 + 32'(i);
      data_valid = 1'b1;
    end
    @(negedge clk);
    data_valid = 1'b0;
    check("sat final", drop_cnt, 255);
    repeat (2 * FRAME + 20) @(negedge clk);
    check("sat drained", {busy, uart_tx, drop_cnt}, {1'b0, 1'b1, 8'hFF});
    do_reset();
    expq.delete();
    dec.delete();
    mon_en = 1'b1;
    cw = '{32'h0, 32'h0, 32'h0, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      data_in = cw[i];
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      repeat (FRAME + 10) @(negedge clk);
    end
    mon_en = 1'b0;
`ifdef N64_UART_CHANGE_ONLY_EN
    expq.push_back('{-1, 32'h0});
    expq.push_back('{-1, 32'h8000_0000});
`else
    for (int i = 0; i < 4; i++) expq.push_back('{-1, cw[i]});
`endif
    cmp_frames("chg");
    check("chg drops", drop_cnt, 0);
    do_reset();
    m_end = -1000;
    m_drop = 0;
    m_pv = 1'b0;
    m_pw = '0;
    m_first = 1'b1;
    m_last = '0;
    expq.delete();
    dec.delete();
    mon_en = 1'b1;
    nxt = 3;
    pw = '0;
    for (int c = 0; c < 9000; c++) begin
      @(negedge clk);
      dv = c == nxt;
      w = $urandom;
      if (dv) begin
        if ($urandom_range(0, 3) == 0) w = pw;
        pw = w;
        nxt = c == 3 ? c + FRAME : c + $urandom_range(1, 700);
      end
      data_valid = dv;
      data_in = w;
      model_step(cyc + 1, dv, w);
    end
    for (int c = 0; c < 3000 && (m_pv || cyc <= m_end + 5); c++) begin
      @(negedge clk);
      data_valid = 1'b0;
      model_step(cyc + 1, 1'b0, '0);
    end
    repeat (5) @(negedge clk);
    mon_en = 1'b0;
    cmp_frames("rand");
    check("rand drops", drop_cnt, m_drop);
    check("rand idle", {busy, uart_tx}, 2'b01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
